// File: rtl/out_port_bank.sv
// rtl/out_port_bank.sv - bank of latched output registers with a write-journal FIFO stream
`timescale 1ns/1ps
module out_port_bank #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_o,
  input  logic [CH_W-1:0]                    chan_sel,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_vals,
  output logic                               stream_valid,
  input  logic                               stream_ready,
  output logic [DATA_WIDTH-1:0]              stream_data,
  output logic [CH_W-1:0]                    stream_chan,
  output logic                               fifo_full,
  output logic                               overflow,
  input  logic                               clear_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = CH_W + DATA_WIDTH;
  localparam logic [CH_W:0]    NUM_CH_C = (CH_W + 1)'(NUM_CHANNELS);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] ch_reg [NUM_CHANNELS];
  logic [ENT_W-1:0]      mem    [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  legal;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Out-of-range channel numbers are ignored entirely, not aliased onto a real channel.
  assign legal        = load_o && ({1'b0, chan_sel} < NUM_CH_C);
  assign fifo_full    = (count == DEPTH_C);
  assign stream_valid = (count != '0);
  assign pop          = stream_valid && stream_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the record.
  assign push         = legal && (!fifo_full || pop);
  assign drop         = legal && fifo_full && !pop;

  // Head is read from registered storage via a registered pointer, so ready never reaches it.
  assign {stream_chan, stream_data} = mem[rd_ptr];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign out_vals[g*DATA_WIDTH +: DATA_WIDTH] = ch_reg[g];
  end

  // Channel registers: the selected channel latches the bus value on a legal write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) ch_reg[i] <= '0;
    end else if (legal) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (chan_sel == CH_W'(i)) ch_reg[i] <= data_in;
      end
    end
  end

  // Journal storage: contents are only meaningful between rd_ptr and wr_ptr, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {chan_sel, data_in};
  end

  // Journal pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a dropped record takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (clear_flags) overflow <= 1'b0;
  end

endmodule
